// File: rtl/seq_reduce_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : reduce_pkg                                               |
// | Purpose  : Shared op codes, FSM state type and op-decoding helpers  |
// |            for the sequential reduction unit.                       |
// | Contents : OP_AND..OP_XNOR, state_t, base_t, identity(),            |
// |            base_op(), is_inverted(), is_reserved()                  |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package reduce_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Primitive fold operator; the complemented ops share their base and
   // only differ in the final inversion.
   typedef enum logic [1:0] {
      BASE_AND = 2'd0,
      BASE_OR  = 2'd1,
      BASE_XOR = 2'd2
   } base_t;

   function automatic logic is_reserved(input logic [2:0] op);
      return (op > OP_XNOR);
   endfunction

   // Starting accumulator value: 1 for AND-type, 0 for everything else
   // (reserved codes included, their result is forced to 0 anyway).
   function automatic logic identity(input logic [2:0] op);
      return (op == OP_AND) || (op == OP_NAND);
   endfunction

   function automatic base_t base_op(input logic [2:0] op);
      base_t b;
      case (op)
         OP_AND, OP_NAND: b = BASE_AND;
         OP_XOR, OP_XNOR: b = BASE_XOR;
         default:         b = BASE_OR;
      endcase
      return b;
   endfunction

   function automatic logic is_inverted(input logic [2:0] op);
      return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_reduce_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : seq_reduce_unit_if                                       |
// | Purpose  : Operand-in / result-out handshake bundle.                |
// | Ports    : in_valid/in_ready/in_data/in_op  (operand side)          |
// |            out_valid/out_ready/out_data/out_err (result side)       |
// |            master = producer/consumer, slave = reduction unit       |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
interface seq_reduce_unit_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic             out_data;
   logic             out_err;

   modport master (
      output in_valid, in_data, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_data, in_op, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface
`default_nettype wire

// File: rtl/seq_reduce_unit_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : reduce_lane                                              |
// | Purpose  : Folds one LANE-bit chunk into the accumulator bit.       |
// | Ports    : chunk    in  LANE  bits to fold                          |
// |            acc      in  1     current accumulator                   |
// |            base     in  2     fold operator (AND/OR/XOR)            |
// |            acc_next out 1     updated accumulator                   |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module reduce_lane
   import reduce_pkg::*;
#(
   parameter int LANE = 4
) (
   input  wire logic [LANE-1:0] chunk,
   input  wire logic            acc,
   input  wire base_t           base,
   output logic                 acc_next
);

   always_comb begin
      acc_next = acc;
      case (base)
         BASE_AND: acc_next = acc & (&chunk);
         BASE_OR:  acc_next = acc | (|chunk);
         BASE_XOR: acc_next = acc ^ (^chunk);
         default:  acc_next = acc;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seq_reduce_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : seq_reduce_unit                                          |
// | Purpose  : Multi-cycle bitwise reduction (AND/OR/XOR and their      |
// |            complements) of a WIDTH-bit operand, LANE bits/cycle.    |
// | Ports    : clk    in  clock                                         |
// |            rst_n  in  synchronous active-low reset                  |
// |            bus    slave modport of seq_reduce_unit_if               |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module seq_reduce_unit
   import reduce_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LANE  = 4
) (
   input wire logic          clk,
   input wire logic          rst_n,
   seq_reduce_unit_if.slave  bus
);

   localparam int CHUNKS = WIDTH / LANE;
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CW-1:0] c_last = CW'(CHUNKS - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic [2:0]       r_op;
   logic             r_acc;
   logic             r_out_valid;
   logic             r_out_data;
   logic             r_out_err;

   logic             w_acc_next;
   logic             w_last;
   base_t            w_base;

   assign w_base = base_op(r_op);
   assign w_last = (r_cnt == c_last);

   reduce_lane #(
      .LANE (LANE)
   ) u_lane (
      .chunk    (r_shift[LANE-1:0]),
      .acc      (r_acc),
      .base     (w_base),
      .acc_next (w_acc_next)
   );

   // Next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (bus.in_valid) w_next_state = RUN;
         RUN:     if (w_last)       w_next_state = DONE;
         DONE:    if (bus.out_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State register plus datapath; the output registers are loaded on the
   // final fold so the result is valid on the same edge that enters DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_op        <= '0;
         r_acc       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= 1'b0;
         r_out_err   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_shift <= bus.in_data;
                  r_op    <= bus.in_op;
                  r_acc   <= identity(bus.in_op);
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_acc   <= w_acc_next;
               r_shift <= r_shift >> LANE;
               if (w_last) begin
                  r_out_valid <= 1'b1;
                  r_out_err   <= is_reserved(r_op);
                  r_out_data  <= is_reserved(r_op) ? 1'b0
                                                   : (w_acc_next ^ is_inverted(r_op));
               end else begin
                  // Held at the terminal value so the counter never wraps.
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_reduce_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_seq_reduce_unit                                       |
// | Purpose  : Self-checking bench for seq_reduce_unit (16/4 and 4/4).  |
// | Revision : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_seq_reduce_unit;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   seq_reduce_unit_if #(.WIDTH(16)) bus  ();
   seq_reduce_unit_if #(.WIDTH(4))  bus1 ();

   seq_reduce_unit #(.WIDTH(16), .LANE(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   seq_reduce_unit #(.WIDTH(4), .LANE(4)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-operand reduction straight from the op definitions.
   task automatic model(input logic [2:0] op, input logic [15:0] d,
                        output logic res, output logic err);
      err = 1'b0;
      case (op)
         3'd0:    res = &d;
         3'd1:    res = |d;
         3'd2:    res = ^d;
         3'd3:    res = ~(&d);
         3'd4:    res = ~(|d);
         3'd5:    res = ~(^d);
         default: begin res = 1'b0; err = 1'b1; end
      endcase
   endtask

   // One transaction on the 16-bit unit, entered with the unit idle.
   task automatic txn(input string tag, input logic [2:0] op, input logic [15:0] d,
                      input int stall);
      logic exp_d, exp_e;
      int   n;
      model(op, d, exp_d, exp_e);
      check({tag, ":in_ready_idle"}, bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_op     = op;
      bus.out_ready = (stall == 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, ":latency"}, n, 4);
      check({tag, ":data"}, bus.out_data, exp_d);
      check({tag, ":err"}, bus.out_err, exp_e);
      check({tag, ":in_ready_busy"}, bus.in_ready, 0);
      if (stall > 0) begin
         // A competing operand offered during the stall must be ignored.
         bus.in_valid = 1'b1;
         bus.in_data  = 16'h0000;
         bus.in_op    = 3'd4;
         for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, ":stall_valid"}, bus.out_valid, 1);
            check({tag, ":stall_data"}, bus.out_data, exp_d);
            check({tag, ":stall_err"}, bus.out_err, exp_e);
            check({tag, ":stall_in_ready"}, bus.in_ready, 0);
         end
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check({tag, ":release_valid"}, bus.out_valid, 0);
      check({tag, ":release_in_ready"}, bus.in_ready, 1);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_op      = '0;
      bus.out_ready  = 1'b1;
      bus1.in_valid  = 1'b0;
      bus1.in_data   = '0;
      bus1.in_op     = '0;
      bus1.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst:in_ready", bus.in_ready, 1);
      check("rst:out_valid", bus.out_valid, 0);
      check("rst:out_data", bus.out_data, 0);
      check("rst:out_err", bus.out_err, 0);
      check("rst1:in_ready", bus1.in_ready, 1);
      check("rst1:out_valid", bus1.out_valid, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      txn("nor_zero",  3'd4, 16'h0000, 0);
      txn("nor_bit",   3'd4, 16'h0100, 0);
      txn("or_bit",    3'd1, 16'h0100, 0);
      txn("xor_ends",  3'd2, 16'h8001, 0);
      txn("xnor_ends", 3'd5, 16'h8001, 0);
      txn("and_ones",  3'd0, 16'hFFFF, 0);
      txn("nand_fe",   3'd3, 16'hFFFE, 0);
      txn("reserved7", 3'd7, 16'h1234, 0);
      txn("reserved6", 3'd6, 16'hFFFF, 0);

      // Backpressure: 5 stalled cycles, then the second operand is
      // accepted only after release.
      txn("stall5",    3'd1, 16'h0000, 5);
      txn("after_stall", 3'd4, 16'h0000, 0);

      // Reset during chunk 2 discards the partially folded operand.
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0F00;
      bus.in_op    = 3'd4;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst:in_ready", bus.in_ready, 1);
      check("midrst:out_valid", bus.out_valid, 0);
      check("midrst:out_data", bus.out_data, 0);
      check("midrst:out_err", bus.out_err, 0);
      repeat (4) @(posedge clk);
      #1;
      check("midrst:no_stale", bus.out_valid, 0);
      txn("midrst_fresh", 3'd4, 16'h0000, 0);

      // Randomized transactions
      for (int i = 0; i < 40; i++) begin
         txn("rand", 3'($urandom_range(0, 7)), 16'($urandom),
             int'($urandom_range(0, 2)));
      end

      // CHUNKS=1 unit: result one cycle after accept
      bus1.in_valid = 1'b1;
      bus1.in_data  = 4'h0;
      bus1.in_op    = 3'd4;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      check("c1:run_valid", bus1.out_valid, 0);
      check("c1:run_in_ready", bus1.in_ready, 0);
      @(posedge clk); #1;
      check("c1:valid", bus1.out_valid, 1);
      check("c1:data", bus1.out_data, 1);
      check("c1:err", bus1.out_err, 0);
      @(posedge clk); #1;
      check("c1:release", bus1.out_valid, 0);
      check("c1:in_ready", bus1.in_ready, 1);
      bus1.in_valid = 1'b1;
      bus1.in_data  = 4'h4;
      bus1.in_op    = 3'd4;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      @(posedge clk); #1;
      check("c1b:valid", bus1.out_valid, 1);
      check("c1b:data", bus1.out_data, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seq_reduce_unit.md
# seq_reduce_unit

Parametrised, multi-cycle bitwise reduction engine that generalises fixed-width NOR reduction to WIDTH-bit operands and six selectable reduction operators. It folds LANE bits per clock through an accumulator, with valid/ready handshakes on both sides. It sits in the simulation-equivalence test area as a sequential counterpart to the purely combinational reduction gates. The ops are AND, OR, XOR and their complements.

## Interface
Parameters:
- WIDTH, 16: operand width in bits; must be at least 1.
- LANE, 4: bits folded per cycle; must divide WIDTH. CHUNKS = WIDTH/LANE.

Ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- in_valid, in, 1: operand and op are valid.
- in_ready, out, 1: unit can accept an operand.
- in_data, in, WIDTH: operand to reduce.
- in_op, in, 3: operator code.
- out_valid, out, 1: result is valid.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, 1: reduction result.
- out_err, out, 1: the latched op was a reserved code.

## Operation
- Op codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR. Codes 6 and 7 are reserved.
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready, latch in_data into the shift register and in_op into the op register.
  - Load the accumulator with the operator identity: 1 for AND/NAND, 0 for OR/NOR/XOR/XNOR.
  - Clear the chunk counter and go to RUN.
- RUN:
  - Each cycle, fold the low LANE bits of the shift register into the accumulator with the base op (AND, OR or XOR).
  - Shift the register right by LANE and increment the counter.
  - After the fold of chunk index CHUNKS-1, go to DONE.
- DONE:
  - out_valid=1.
  - out_data = accumulator, inverted for NAND/NOR/XNOR.
  - On out_ready, go to IDLE.
- Reserved op: folding proceeds normally; in DONE, out_data=0 and out_err=1.
- in_ready is 0 in RUN and DONE. in_valid in those states is ignored, not queued.
- out_data and out_err are held stable while out_valid=1 and out_ready=0.

## Timing
- Reset values (any state, including mid-RUN):
  - in_ready=1, out_valid=0, out_data=0, out_err=0.
  - Accumulator, counter and op register cleared.
  - A partially folded operand is discarded.
- Latency:
  - Operand accepted at edge k → out_valid rises after edge k+CHUNKS.
  - With out_ready held high, out_valid stays up for exactly one cycle. in_ready returns after edge k+CHUNKS+1.
- Throughput: one result per CHUNKS+2 cycles when unstalled.
- Counter width is $clog2(CHUNKS) bits, minimum 1.
  - CHUNKS=1 is legal: RUN lasts one cycle.
  - The terminal comparison is against CHUNKS-1, so the counter never wraps in use.
- out_valid, out_data and out_err are registered outputs. in_ready is decoded from state.

## Structure
- Package reduce_pkg holds:
  - the op-code constants (OP_AND … OP_XNOR);
  - the state enum {IDLE, RUN, DONE};
  - helper functions identity(op), base_op(op) and is_inverted(op).
- Sub-module reduce_lane: combinational, parameter LANE. Inputs are a LANE-bit chunk, the accumulator bit and the base op; output is the next accumulator bit.
- Top level: FSM, shift register, counter and output registers.

## Test plan
Default WIDTH=16, LANE=4 unless stated.
- **NOR of zero:** op 4, in_data 0x0000 accepted at edge k → out_valid after edge k+4, out_data=1, out_err=0.
- **NOR with one bit set:** op 4, in_data 0x0100 → out_data=0. Also op 1 on 0x0100 → 1.
- **XOR/XNOR and AND:**
  - op 2 on 0x8001 → 0; op 5 on 0x8001 → 1.
  - op 0 on 0xFFFF → 1; op 3 on 0xFFFE → 1.
- **Backpressure:** out_ready=0 for 5 cycles in DONE → out_valid, out_data and in_ready=0 held. A second in_valid during the stall is not accepted; it is accepted only after the release cycle.
- **Reset mid-RUN:** rst_n=0 for one edge during chunk 2 → next cycle in_ready=1, out_valid=0. A fresh op 4 on 0x0000 then yields 1 with the normal 4-cycle latency.
- **Reserved op and CHUNKS=1:**
  - op 7 → out_data=0, out_err=1.
  - With WIDTH=4, LANE=4: op 4 on 0x0 → out_valid one cycle after accept, out_data=1.
